// File: rtl/dsp_pipe_chain.sv
// -----------------------------------------------------------------------------
// dsp_pipe_chain
//
// Elastic register chain for DSP operand/result paths. It places DEPTH register
// stages between an operand source and the pre-adder/multiplier/post-adder
// stages wherever multi-cycle balancing is needed. Each stage has its own valid
// bit. Words move forward with ready/valid handshakes, and bubbles collapse: a
// stage drains into an empty successor even while the output is stalled.
//
// Parameters
//   WIDTH  data width in bits (>= 1)
//   DEPTH  number of register stages (0..8); 0 = pure combinational bypass
//   CW     width of the occupancy count (derived, minimum 1)
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous active-high reset
//   ce         in   1      clock enable; 0 freezes the chain and blocks transfers
//   clr        in   1      synchronous flush of all stage valid bits
//   in_valid   in   1      upstream word valid
//   in_data    in   WIDTH  upstream word
//   in_ready   out  1      chain accepts in_data this cycle
//   out_valid  out  1      out_data valid
//   out_data   out  WIDTH  word held in the last stage
//   out_ready  in   1      downstream accepts out_data
//   count      out  CW     number of occupied stages (0..DEPTH)
// -----------------------------------------------------------------------------
module dsp_pipe_chain #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 2,
    localparam int CW = (DEPTH < 1) ? 1 : $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CW-1:0]    count
);

    if (DEPTH > 0) begin : g_pipe

        // Stage k: index 0 sits on the input side, DEPTH-1 on the output side.
        logic [DEPTH-1:0] stage_valid;
        logic [WIDTH-1:0] stage_data [DEPTH];

        // room[k] is high when stage k can accept a word this cycle: it is
        // either empty or handing its own word forward. room[DEPTH] stands for
        // the downstream consumer, so the last stage needs no special case.
        logic [DEPTH:0]   room;
        logic [DEPTH-1:0] stage_move;
        logic [DEPTH-1:0] stage_load;

        logic             in_ready_int;
        logic             in_xfer;
        logic             out_xfer;
        logic [CW-1:0]    count_reg;
        logic [CW-1:0]    count_next;

        // Ready ripples from the output toward the input within one cycle. The
        // loop runs from the output side down, so each room[k+1] is computed
        // before it is read.
        always_comb begin
            room       = '0;
            stage_move = '0;
            room[DEPTH] = out_ready;
            for (int k = DEPTH - 1; k >= 0; k--) begin
                stage_move[k] = ce & stage_valid[k] & room[k + 1];
                room[k]       = ~stage_valid[k] | stage_move[k];
            end
        end

        // A stage loads whenever it has room. A flush overrides every load.
        assign stage_load = {DEPTH{ce & ~clr}} & room[DEPTH-1:0];

        // While reset is held, no word may be accepted, even though the empty
        // chain would otherwise report room.
        assign in_ready_int = stage_load[0] & ~rst;
        assign in_xfer      = in_valid & in_ready_int;
        assign out_xfer     = ce & stage_valid[DEPTH-1] & out_ready;

        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic             src_valid;
            logic [WIDTH-1:0] src_data;
            logic             valid_reg;
            logic [WIDTH-1:0] data_reg;

            if (gi == 0) begin : g_src_in
                assign src_valid = in_valid;
                assign src_data  = in_data;
            end else begin : g_src_prev
                // When this stage loads, its predecessor is moving. The
                // predecessor's valid bit is therefore the valid bit of the
                // word being handed over.
                assign src_valid = stage_valid[gi-1];
                assign src_data  = stage_data[gi-1];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                    data_reg  <= '0;
                end else if (clr) begin
                    // The flush drops the words but keeps the data registers,
                    // so out_data does not glitch.
                    valid_reg <= 1'b0;
                end else if (stage_load[gi]) begin
                    valid_reg <= src_valid;
                    // On a bubble, keep the old data to avoid useless toggling.
                    if (src_valid) begin
                        data_reg <= src_data;
                    end
                end
            end

            assign stage_valid[gi] = valid_reg;
            assign stage_data[gi]  = data_reg;
        end

        // Occupancy: a simultaneous accept and emit leaves the count as it was.
        always_comb begin
            count_next = count_reg;
            if (in_xfer && !out_xfer) begin
                count_next = count_reg + CW'(1);
            end else if (out_xfer && !in_xfer) begin
                count_next = count_reg - CW'(1);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                count_reg <= '0;
            end else if (clr) begin
                count_reg <= '0;
            end else begin
                count_reg <= count_next;
            end
        end

        assign in_ready  = in_ready_int;
        assign out_valid = ce & stage_valid[DEPTH-1];
        assign out_data  = stage_data[DEPTH-1];
        assign count     = count_reg;

    end else begin : g_bypass

        // Zero-depth chain: the handshake passes straight through. Enable and
        // flush still gate the transfers, so the handshake behaves the same as
        // in a registered chain.
        logic unused_bypass;

        assign out_valid     = in_valid & ce;
        assign out_data      = in_data;
        assign in_ready      = out_ready & ce & ~clr;
        assign count         = '0;
        assign unused_bypass = &{1'b0, clk, rst};

    end

endmodule

// File: tb/tb_dsp_pipe_chain.sv
// -----------------------------------------------------------------------------
// tb_dsp_pipe_chain
//
// Bench for dsp_pipe_chain, DEPTH=3 and WIDTH=8, with a DEPTH=0 instance for
// the bypass case. Inputs change 1 ns after each rising edge. Directed checks
// sample at edge+4 ns. A scoreboard queue records every accepted word and
// checks every emitted word at the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dsp_pipe_chain;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             ce;
    logic             clr;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [1:0]       count;

    logic             bp_ce;
    logic             bp_clr;
    logic             bp_in_valid;
    logic [WIDTH-1:0] bp_in_data;
    logic             bp_in_ready;
    logic             bp_out_valid;
    logic [WIDTH-1:0] bp_out_data;
    logic             bp_out_ready;
    logic [0:0]       bp_count;

    int               checks = 0;
    int               errors = 0;
    logic [WIDTH-1:0] sb_q[$];
    logic [WIDTH-1:0] sb_exp;

    always #5 clk = ~clk;

    dsp_pipe_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
    );

    dsp_pipe_chain #(.WIDTH(WIDTH), .DEPTH(0)) u_dut_bp (
        .clk       (clk),
        .rst       (rst),
        .ce        (bp_ce),
        .clr       (bp_clr),
        .in_valid  (bp_in_valid),
        .in_data   (bp_in_data),
        .in_ready  (bp_in_ready),
        .out_valid (bp_out_valid),
        .out_data  (bp_out_data),
        .out_ready (bp_out_ready),
        .count     (bp_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Move to 1 ns after the next rising edge, where the inputs are driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Empty the chain with out_ready held high, for at most 20 cycles.
    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (count != 2'd0 && guard < 20) begin
            tick();
            in_valid  = 1'b0;
            out_ready = 1'b1;
            #3;
            guard++;
        end
        check_eq(tag, count, 0);
    endtask

    // Scoreboard: a flush discards whatever the chain held.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check_eq("sb_unexpected_out", {24'd0, out_data}, 32'h100);
                end else begin
                    sb_exp = sb_q.pop_front();
                    check_eq("sb_out_data", out_data, sb_exp);
                end
                $display("[%0t] out 0x%02h", $time, out_data);
            end
            if (clr) begin
                sb_q.delete();
            end else if (in_valid && in_ready) begin
                sb_q.push_back(in_data);
                $display("[%0t] in  0x%02h", $time, in_data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int idx;
        int nout;
        int guard;
        int exp_cnt;
        logic [1:0]       frz_count;
        logic [WIDTH-1:0] frz_data;

        rst = 1'b1; ce = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        bp_ce = 1'b1; bp_clr = 1'b0; bp_in_valid = 1'b0; bp_in_data = '0; bp_out_ready = 1'b0;

        // Reset state
        tick();
        #3;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_count", count, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_in_ready", in_ready, 0);
        tick();
        rst = 1'b0;

        // 1: back-to-back stream 0x01..0x05 with out_ready=1
        out_ready = 1'b1;
        for (int j = 0; j < 9; j++) begin
            tick();
            in_valid = (j < 5);
            in_data  = 8'(j + 1);
            #3;
            exp_cnt = ((j < 5) ? j : 5) - ((j > 3) ? (j - 3) : 0);
            check_eq("t1_in_ready", in_ready, 1);
            check_eq("t1_out_valid", out_valid, (j >= 3 && j <= 7));
            if (j >= 3 && j <= 7) check_eq("t1_out_data", out_data, j - 2);
            check_eq("t1_count", count, exp_cnt);
        end

        // 2: stalled output fills the chain, then releases in order
        out_ready = 1'b0;
        idx = 0;
        nout = 0;
        for (int j = 0; j < 5; j++) begin
            tick();
            in_valid = (idx < 5);
            in_data  = 8'hA0 + 8'(idx);
            #3;
            if (in_valid && in_ready) idx++;
        end
        check_eq("t2_accepted", idx, 3);
        check_eq("t2_count_full", count, 3);
        check_eq("t2_in_ready_full", in_ready, 0);
        check_eq("t2_out_valid", out_valid, 1);
        check_eq("t2_out_head", out_data, 8'hA0);
        guard = 0;
        while (nout < 5 && guard < 20) begin
            tick();
            out_ready = 1'b1;
            in_valid  = (idx < 5);
            in_data   = 8'hA0 + 8'(idx);
            #3;
            check_eq("t2_no_gap", out_valid, 1);
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready) nout++;
            guard++;
        end
        check_eq("t2_emitted", nout, 5);
        tick();
        in_valid = 1'b0;
        #3;
        check_eq("t2_count_empty", count, 0);

        // 3: bubble collapse while output is stalled
        out_ready = 1'b0;
        tick(); in_valid = 1'b1; in_data = 8'h55; #3;
        check_eq("t3_in_ready", in_ready, 1);
        tick(); in_valid = 1'b0; #3;
        check_eq("t3_lat1", out_valid, 0);
        tick(); #3;
        check_eq("t3_lat2", out_valid, 0);
        tick(); #3;
        check_eq("t3_lat3_valid", out_valid, 1);
        check_eq("t3_lat3_data", out_data, 8'h55);
        check_eq("t3_count1", count, 1);
        tick(); in_valid = 1'b1; in_data = 8'h66; #3;
        check_eq("t3_in_ready2", in_ready, 1);
        tick(); in_valid = 1'b0; #3;
        tick(); #3;
        tick(); #3;
        check_eq("t3_count2", count, 2);
        check_eq("t3_in_ready_room", in_ready, 1);
        check_eq("t3_head_held", out_data, 8'h55);
        drain("t3_drain");

        // 4: clock enable low for 4 cycles mid-stream
        out_ready = 1'b1;
        idx = 0;
        frz_count = '0;
        frz_data  = '0;
        for (int j = 0; j < 16; j++) begin
            tick();
            ce       = !(j >= 4 && j < 8);
            in_valid = (idx < 8);
            in_data  = 8'hB0 + 8'(idx);
            #3;
            if (j == 4) begin
                frz_count = count;
                frz_data  = out_data;
            end
            if (j >= 4 && j < 8) begin
                check_eq("t4_in_ready", in_ready, 0);
                check_eq("t4_out_valid", out_valid, 0);
            end
            if (j > 4 && j < 8) begin
                check_eq("t4_count_frozen", count, frz_count);
                check_eq("t4_data_frozen", out_data, frz_data);
            end
            if (in_valid && in_ready) idx++;
        end
        ce = 1'b1;
        check_eq("t4_accepted", idx, 8);
        drain("t4_drain");
        check_eq("t4_sb_empty", sb_q.size(), 0);

        // 5: flush a full chain while 0x77 is offered
        out_ready = 1'b0;
        idx = 0;
        guard = 0;
        while (count != 2'd3 && guard < 10) begin
            tick();
            in_valid = (idx < 3);
            in_data  = 8'hC0 + 8'(idx);
            #3;
            if (in_valid && in_ready) idx++;
            guard++;
        end
        check_eq("t5_full", count, 3);
        tick(); clr = 1'b1; in_valid = 1'b1; in_data = 8'h77; #3;
        check_eq("t5_clr_in_ready", in_ready, 0);
        check_eq("t5_clr_out_valid", out_valid, 1);
        tick(); clr = 1'b0; in_valid = 1'b0; #3;
        check_eq("t5_count_cleared", count, 0);
        check_eq("t5_out_valid_cleared", out_valid, 0);
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick(); #3;
            check_eq("t5_no_77", out_valid, 0);
        end

        // 6: asynchronous reset pulse between edges with two words held
        out_ready = 1'b0;
        idx = 0;
        guard = 0;
        while (count != 2'd2 && guard < 10) begin
            tick();
            in_valid = (idx < 2);
            in_data  = 8'hD0 + 8'(idx);
            #3;
            if (in_valid && in_ready) idx++;
            guard++;
        end
        tick();
        in_valid = 1'b0;
        #1;
        check_eq("t6_pre_count", count, 2);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        check_eq("t6_rst_out_valid", out_valid, 0);
        check_eq("t6_rst_count", count, 0);
        check_eq("t6_rst_out_data", out_data, 0);
        sb_q.delete();
        tick(); out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hE5; #3;
        check_eq("t6_accept_after_rst", in_ready, 1);
        tick(); in_valid = 1'b0; #3;
        drain("t6_drain");
        check_eq("t6_sb_empty", sb_q.size(), 0);

        // DEPTH=0 bypass instance: purely combinational
        tick();
        for (int i = 0; i < 8; i++) begin
            bp_in_data   = 8'($urandom);
            bp_in_valid  = 1'($urandom);
            bp_out_ready = 1'($urandom);
            bp_ce        = (i != 3);
            bp_clr       = (i == 5);
            #1;
            check_eq("bp_out_data", bp_out_data, bp_in_data);
            check_eq("bp_in_ready", bp_in_ready, bp_out_ready & bp_ce & ~bp_clr);
            check_eq("bp_out_valid", bp_out_valid, bp_in_valid & bp_ce);
            check_eq("bp_count", bp_count, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
